// File: rtl/wb_burst_mem_slave.sv
// Wishbone memory slave with classic, constant and incrementing (linear/wrap) bursts.
// Responses are decoded from registered state, with an optional fixed wait-state delay.
`timescale 1ns/1ps
module wb_burst_mem_slave #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [aw-1:0]   wb_adr_i,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic [dw/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [dw-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o
);
    // state  | meaning
    // IDLE   | no request in progress
    // WAIT   | wait-state countdown before the response
    // RESP   | ack (in range) or err (out of range) presented
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int         OFS   = $clog2(dw / 8);
    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [aw-1:0] adr_q, adr_d, adr_nxt;
    logic [dw-1:0] mem [DEPTH];
    logic          req, in_range, resp, burst, wr_en;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_range = (adr_q >> IDX_W) == '0;
    assign resp     = (state_q == S_RESP);
    assign burst    = (wb_cti_i == 3'b001) || (wb_cti_i == 3'b010);

    // Wrapping bursts only advance the low index bits; linear wraps at DEPTH.
    always_comb begin
        adr_nxt = adr_q;
        case (wb_bte_i)
            2'b01:   adr_nxt[1:0] = adr_q[1:0] + 2'd1;
            2'b10:   adr_nxt[2:0] = adr_q[2:0] + 3'd1;
            2'b11:   adr_nxt[3:0] = adr_q[3:0] + 4'd1;
            default: adr_nxt[IDX_W-1:0] = adr_q[IDX_W-1:0] + IDX_W'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    adr_d = wb_adr_i >> OFS;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (!req || !in_range || !burst) begin
                    state_d = S_IDLE;
                end else begin
                    if (wb_cti_i == 3'b010) adr_d = adr_nxt;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
        end
    end

    // Memory is deliberately not reset; a reset only cancels the pending beat.
    assign wr_en = resp & in_range & req & wb_we_i;

    always_ff @(posedge wb_clk) begin
        if (wr_en) begin
            for (int b = 0; b < dw / 8; b++) begin
                if (wb_sel_i[b]) mem[adr_q[IDX_W-1:0]][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
            end
        end
    end

    assign wb_ack_o = resp & in_range;
    assign wb_err_o = resp & ~in_range;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = (resp && in_range && !wb_we_i) ? mem[adr_q[IDX_W-1:0]] : '0;
endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) driven by a Wishbone master model,
// expected responses queued at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_wb_burst_mem_slave;
    typedef struct {
        bit          is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        wb_rst;
    logic [31:0] adr, dat_w;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        cyc0, stb0, cyc1, stb1;
    logic [31:0] dat0, dat1;
    logic        ack0, err0, rty0, ack1, err1, rty1;
    logic        ack_m, err_m;
    logic [31:0] dat_m;
    int          tgt = 0;
    int          cyc_n = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mref [2][256];
    exp_t        sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    wb_burst_mem_slave #(.dw(32), .aw(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .wb_clk(clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0));

    wb_burst_mem_slave #(.dw(32), .aw(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .wb_clk(clk), .wb_rst(wb_rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc1), .wb_stb_i(stb1), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1), .wb_rty_o(rty1));

    assign ack_m = (tgt == 1) ? ack1 : ack0;
    assign err_m = (tgt == 1) ? err1 : err0;
    assign dat_m = (tgt == 1) ? dat1 : dat0;

    // Monitor: every negedge, pop an expectation whenever the active slave responds.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ((ack0 && err0) || (ack1 && err1) || rty0 || rty1) begin
            errors++;
            $display("FAIL ack_err_rty: ack0=%0b err0=%0b rty0=%0b ack1=%0b err1=%0b rty1=%0b, required ack/err exclusive and rty=0",
                     ack0, err0, rty0, ack1, err1, rty1);
        end
        if (ack_m || err_m) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b at cycle %0d, required no response", ack_m, err_m, cyc_n);
            end else begin
                e = sbq.pop_front();
                checks += 3;
                if (err_m !== e.is_err || ack_m !== !e.is_err) begin
                    errors++;
                    $display("FAIL resp_kind: ack=%0b err=%0b, required err=%0b", ack_m, err_m, e.is_err);
                end
                if (dat_m !== e.data) begin
                    errors++;
                    $display("FAIL resp_data: got %h, required %h", dat_m, e.data);
                end
                if (cyc_n != e.cyc) begin
                    errors++;
                    $display("FAIL resp_latency: response at cycle %0d, required cycle %0d", cyc_n, e.cyc);
                end
            end
        end else begin
            checks++;
            if (dat_m !== 32'h0) begin
                errors++;
                $display("FAIL idle_dat: dat_o=%h with no response, required 0", dat_m);
            end
        end
    end

    function automatic int next_word(input int w, input logic [1:0] bt);
        case (bt)
            2'b01:   return (w / 4) * 4 + (w + 1) % 4;
            2'b10:   return (w / 8) * 8 + (w + 1) % 8;
            2'b11:   return (w / 16) * 16 + (w + 1) % 16;
            default: return (w + 1) % 256;
        endcase
    endfunction

    task automatic set_req(input int t, input logic v);
        if (t == 1) begin cyc1 = v; stb1 = v; end
        else        begin cyc0 = v; stb0 = v; end
    endtask

    // Master model: n beats starting at byte address a; mode 0 classic, 1 constant, 2 incrementing.
    task automatic txn(input int t, input logic [31:0] a, input bit w_e, input int n,
                       input logic [2:0] mode, input logic [1:0] bt, input int abort_beat,
                       input logic [31:0] dfix, input logic [3:0] sfix, input bit rnd);
        int          w, rc, wst;
        bit          got;
        logic [31:0] d;
        logic [3:0]  s;
        exp_t        e;
        wst = (t == 1) ? 3 : 0;
        tgt = t;
        w   = int'(a >> 2);
        rc  = cyc_n;
        for (int i = 0; i < n; i++) begin
            d = rnd ? $urandom : dfix;
            s = rnd ? 4'($urandom_range(0, 15)) : sfix;
            adr = a; we = w_e; dat_w = d; sel = s; bte = bt;
            cti = (mode == 3'b000) ? 3'b000 : ((i == n - 1) ? 3'b111 : mode);
            e.is_err = (w >= 256);
            e.data   = (!e.is_err && !w_e) ? mref[t][w] : 32'h0;
            e.cyc    = rc + 1 + wst;
            sbq.push_back(e);
            set_req(t, 1'b1);
            got = 0;
            for (int k = 0; k < 40 && !got; k++) begin
                @(negedge clk); #1;
                if (ack_m || err_m) got = 1;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL timeout: no response for beat %0d at word %0d, required one", i, w);
                set_req(t, 1'b0);
                sbq.delete();
                return;
            end
            rc = cyc_n;
            if (i == abort_beat) begin
                wb_rst = 1'b1;
                #1;
                checks++;
                if (ack_m || err_m || dat_m !== 32'h0) begin
                    errors++;
                    $display("FAIL rst_immediate: ack=%0b err=%0b dat=%h, required all 0", ack_m, err_m, dat_m);
                end
                set_req(t, 1'b0);
                @(negedge clk); #1;
                wb_rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (!e.is_err && w_e) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mref[t][w][b*8 +: 8] = d[b*8 +: 8];
            end
            if (e.is_err) break;
            if (mode == 3'b010) w = next_word(w, bt);
        end
        set_req(t, 1'b0);
    endtask

    initial begin
        wb_rst = 1'b1;
        adr = 0; dat_w = 0; sel = 0; we = 0; cti = 0; bte = 0;
        cyc0 = 0; stb0 = 0; cyc1 = 0; stb1 = 0;
        #2;
        checks++;
        if (ack0 || err0 || rty0 || dat0 !== 32'h0 || ack1 || err1 || rty1 || dat1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ack0=%0b err0=%0b dat0=%h ack1=%0b err1=%0b dat1=%h, required all 0",
                     ack0, err0, dat0, ack1, err1, dat1);
        end
        repeat (2) @(negedge clk);
        #1 wb_rst = 1'b0;
        @(posedge clk); #1;

        for (int t = 0; t < 2; t++)
            for (int w = 0; w < 256; w++)
                txn(t, 32'(w * 4), 1'b1, 1, 3'b000, 2'b00, -1, $urandom, 4'hF, 1'b0);

        // Classic full-word write/read, then a single-lane update
        txn(0, 32'h10, 1'b1, 1, 3'b000, 2'b00, -1, 32'hDEADBEEF, 4'hF, 1'b0);
        txn(0, 32'h10, 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        txn(0, 32'h10, 1'b1, 1, 3'b000, 2'b00, -1, 32'h0000AA00, 4'b0010, 1'b0);
        txn(0, 32'h10, 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        // wrap4 read burst from word 7, then out-of-range write and read-back of word 0
        txn(0, 32'h1C, 1'b0, 4, 3'b010, 2'b01, -1, 32'h0, 4'hF, 1'b0);
        txn(0, 32'h400, 1'b1, 1, 3'b000, 2'b00, -1, 32'h12345678, 4'hF, 1'b0);
        txn(0, 32'h0, 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        // Wait-state slave: normal read, then abort after two wait cycles
        txn(1, 32'h10, 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        tgt = 1; adr = 32'h10; we = 0; cti = 3'b000; bte = 2'b00;
        set_req(1, 1'b1);
        repeat (3) @(posedge clk);
        #1 set_req(1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++;
            if (ack1 || err1) begin
                errors++;
                $display("FAIL abort_quiet: ack=%0b err=%0b after stb dropped, required 0", ack1, err1);
            end
        end
        txn(1, 32'h14, 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        // Reset during the third beat of a write burst, then read the burst words back
        txn(0, 32'(40 * 4), 1'b1, 4, 3'b010, 2'b00, 2, 32'h0, 4'hF, 1'b1);
        for (int w = 40; w < 44; w++)
            txn(0, 32'(w * 4), 1'b0, 1, 3'b000, 2'b00, -1, 32'h0, 4'hF, 1'b0);
        txn(0, 32'(254 * 4), 1'b0, 4, 3'b010, 2'b00, -1, 32'h0, 4'hF, 1'b0);

        for (int k = 0; k < 90; k++) begin
            int          tt, kind, n;
            logic [2:0]  mode;
            logic [31:0] a;
            tt   = (k < 65) ? 0 : 1;
            kind = $urandom_range(0, 3);
            mode = (kind == 1) ? 3'b010 : (kind == 2) ? 3'b001 : 3'b000;
            n    = (mode == 3'b000) ? 1 : $urandom_range(1, 6);
            a    = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 400) * 4)
                                                : 32'($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
            txn(tt, a, 1'($urandom_range(0, 1)), n, mode, 2'($urandom_range(0, 3)), -1, 32'h0, 4'h0, 1'b1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_resp: %0d expected responses never seen, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_burst_mem_slave.md
WB_BURST_MEM_SLAVE -- requirements
Module: wb_burst_mem_slave

Interface
REQ-001 Parameter dw, default 32: data width in bits, a multiple of 8.
REQ-002 Parameter aw, default 32: address width in bits.
REQ-003 Parameter DEPTH, default 256: memory size in dw-bit words, a power of 2.
REQ-004 Parameter WAIT_STATES, default 0: extra cycles before each response, range 0..15.
REQ-005 wb_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 wb_rst  in  1  reset, asynchronous, active-high.
REQ-007 wb_adr_i  in  aw  byte address; word index = wb_adr_i >> log2(dw/8).
REQ-008 wb_dat_i  in  dw  write data.
REQ-009 wb_sel_i  in  dw/8  byte enables.
REQ-010 wb_we_i  in  1  1 = write, 0 = read.
REQ-011 wb_cyc_i, wb_stb_i  in  1 each  bus cycle and strobe; a request is cyc&stb.
REQ-012 wb_cti_i  in  3  cycle type: 000 classic, 001 constant burst, 010 incrementing burst, 111 end of burst.
REQ-013 wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-014 wb_dat_o  out  dw  read data.
REQ-015 wb_ack_o, wb_err_o, wb_rty_o  out  1 each  registered responses.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: no request in progress.
- WAIT: response delay in progress.
- RESP: wb_ack_o or wb_err_o is high.
REQ-017 IDLE with a request at an edge SHALL latch the word index from wb_adr_i into an internal address register.
- WAIT_STATES=0: go to RESP.
- Otherwise: load a 4-bit counter with WAIT_STATES and go to WAIT.
REQ-018 WAIT SHALL decrement the counter each edge and go to RESP when the counter reaches 1.
- Response latency SHALL be WAIT_STATES+1 edges after the request edge.
REQ-019 A request is in range when the word index < DEPTH. In RESP:
- in range: wb_ack_o=1;
- out of range: wb_err_o=1, no memory write, wb_dat_o=0.
REQ-020 In RESP with an in-range read, wb_dat_o SHALL equal the memory word at the internal address. In all other cycles wb_dat_o SHALL be 0.
REQ-021 In RESP with an in-range write, at the edge ending RESP, each byte lane with wb_sel_i=1 SHALL be written from wb_dat_i. Other lanes are unchanged.
REQ-022 Exit from RESP at the edge:
- err, cti 000, or cti 111 sampled: go to IDLE. Responses SHALL be low for at least one cycle between classic accesses.
- cti 001 or 010: go to RESP again if WAIT_STATES=0 (back-to-back acks), else to WAIT reloaded with WAIT_STATES.
REQ-023 Incrementing burst (cti 010) SHALL advance the internal address by one word per acked beat; cti 001 SHALL keep it unchanged.
- bte 00: linear, with wrap at DEPTH-1 to 0.
- bte 01/10/11: only the low 2/3/4 bits of the word index increment modulo 4/8/16; upper bits are held.
REQ-024 If cyc&stb is low at any edge in WAIT or RESP, the FSM SHALL go to IDLE with no response and no write (abort).
REQ-025 A beat whose next address leaves the range SHALL respond with wb_err_o, and the burst SHALL then end.
REQ-026 wb_ack_o and wb_err_o SHALL never be high in the same cycle. wb_rty_o SHALL be constantly 0.

Reset
REQ-027 While wb_rst=1, outputs SHALL be forced immediately (not waiting for a clock edge): wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0, FSM=IDLE, counter=0, address register=0.
REQ-028 Reset SHALL NOT clear memory contents. Reset mid-burst SHALL abort the burst with no further response or write.
REQ-029 After wb_rst falls, the first request SHALL be accepted at the first rising edge where cyc&stb=1.

Verification
All scenarios use dw=32, DEPTH=256, WAIT_STATES=0 unless stated.
REQ-030 Classic write of 0xDEADBEEF to 0x10, sel=1111, then classic read of 0x10 -> ack one cycle after each request edge, ack low in between, read returns 0xDEADBEEF.
REQ-031 Write of 0x0000AA00 to 0x10 with sel=0010, then read of 0x10 -> 0xDEADAAEF.
REQ-032 Incrementing wrap4 burst at 0x1C (word 7), 4 reads with the last beat at cti=111 -> ack high for 4 consecutive cycles, data from words 7, 4, 5, 6, then ack low.
REQ-033 Classic write to 0x400 (word 256) -> wb_err_o high one cycle, wb_ack_o low, word 0 unchanged.
REQ-034 WAIT_STATES=3, classic read of 0x10 -> ack on the 4th edge after the request edge. Second case: stb dropped after 2 wait cycles -> no ack or err, FSM in IDLE.
REQ-035 wb_rst pulsed between edges mid-burst -> wb_ack_o=0 before the next edge; a later read of a word written earlier returns its old value.
